// File: rtl/crc_serial_engine_pkg.sv
// Shared types and USB CRC constants for the serial CRC engine.
package crc_serial_engine_pkg;

  typedef enum logic [1:0] {IDLE, CALC, APPEND} state_t;
  typedef enum logic {CRC_SEL0 = 1'b0, CRC_SEL1 = 1'b1} crc_sel_t;
  typedef enum logic {MODE_GEN = 1'b0, MODE_CHK = 1'b1} crc_mode_t;

  localparam int          USB_CRC5_W     = 5;
  localparam logic [4:0]  USB_CRC5_POLY  = 5'h05;
  localparam logic [4:0]  USB_CRC5_RES   = 5'h0C;
  localparam int          USB_CRC16_W    = 16;
  localparam logic [15:0] USB_CRC16_POLY = 16'h8005;
  localparam logic [15:0] USB_CRC16_RES  = 16'h800D;
  localparam logic        CRC_INIT_BIT   = 1'b1;

endpackage

// File: rtl/crc_serial_engine_if.sv
// Serial bitstream and control bundle between the packet codec and the CRC engine.
interface crc_serial_engine_if;
  logic clear;
  logic start;
  logic pkttype;
  logic chk_mode;
  logic inb;
  logic recving;
  logic pause_out;
  logic pause_in;
  logic outb;
  logic sending;
  logic crc_done;
  logic crc_ok;

  modport slave (
    input  clear, start, pkttype, chk_mode, inb, recving, pause_out,
    output pause_in, outb, sending, crc_done, crc_ok
  );

  modport master (
    output clear, start, pkttype, chk_mode, inb, recving, pause_out,
    input  pause_in, outb, sending, crc_done, crc_ok
  );
endinterface

// File: rtl/crc_serial_engine_lfsr.sv
// MSB-first serial CRC register; init has priority over shift.
module crc_serial_engine_lfsr
  import crc_serial_engine_pkg::*;
#(
  parameter int         W    = 5,
  parameter logic [W-1:0] POLY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] q
);

  logic fb;

  assign fb = din ^ q[W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {W{CRC_INIT_BIT}};
    end else if (init) begin
      q <= {W{CRC_INIT_BIT}};
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/crc_serial_engine.sv
// Serial CRC generate/append and check engine with two per-packet CRC flavours.
module crc_serial_engine
  import crc_serial_engine_pkg::*;
#(
  parameter int                CRC0_W    = USB_CRC5_W,
  parameter logic [CRC0_W-1:0] CRC0_POLY = USB_CRC5_POLY,
  parameter logic [CRC0_W-1:0] CRC0_RES  = USB_CRC5_RES,
  parameter int                CRC1_W    = USB_CRC16_W,
  parameter logic [CRC1_W-1:0] CRC1_POLY = USB_CRC16_POLY,
  parameter logic [CRC1_W-1:0] CRC1_RES  = USB_CRC16_RES,
  parameter int                MAXW      = 16
) (
  input logic                 clk,
  input logic                 rst,
  crc_serial_engine_if.slave  bus
);

  localparam int CW = $clog2(MAXW);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wchk
      localparam int WCHK = (gi == 0) ? CRC0_W : CRC1_W;
      if (WCHK > MAXW || WCHK < 2) begin : g_bad_width
        $error("crc_serial_engine: CRC width %0d outside 2..%0d", WCHK, MAXW);
      end
    end
  endgenerate

  state_t          state_reg;
  crc_sel_t        sel_reg;
  crc_mode_t       mode_reg;
  logic [CW-1:0]   cnt_reg;
  logic            done_reg;
  logic            ok_reg;

  logic [CRC0_W-1:0] crc0_q;
  logic [CRC1_W-1:0] crc1_q;
  logic [MAXW-1:0]   crc_cur;
  logic [CW-1:0]     last_idx;
  logic [CW-1:0]     bit_idx;
  logic              crc_bit;
  logic              res_ok;
  logic              append_done;
  logic              lfsr_init;
  logic              lfsr_shift;

  assign crc_cur     = (sel_reg == CRC_SEL1) ? MAXW'(crc1_q) : MAXW'(crc0_q);
  assign last_idx    = (sel_reg == CRC_SEL1) ? CW'(CRC1_W - 1) : CW'(CRC0_W - 1);
  // cnt is 0 during CALC, so this also yields the MSB for the first appended bit
  assign bit_idx     = last_idx - cnt_reg;
  assign crc_bit     = ~crc_cur[bit_idx];
  assign res_ok      = (sel_reg == CRC_SEL1) ? (crc1_q == CRC1_RES) : (crc0_q == CRC0_RES);
  assign append_done = (state_reg == APPEND) && !bus.pause_out && (cnt_reg == last_idx);
  assign lfsr_init   = bus.clear || (state_reg == IDLE) || append_done;
  assign lfsr_shift  = (state_reg == CALC) && bus.recving && !bus.pause_out;

  crc_serial_engine_lfsr #(.W(CRC0_W), .POLY(CRC0_POLY)) u_lfsr0 (
    .clk   (clk),
    .rst   (rst),
    .init  (lfsr_init),
    .shift (lfsr_shift),
    .din   (bus.inb),
    .q     (crc0_q)
  );

  crc_serial_engine_lfsr #(.W(CRC1_W), .POLY(CRC1_POLY)) u_lfsr1 (
    .clk   (clk),
    .rst   (rst),
    .init  (lfsr_init),
    .shift (lfsr_shift),
    .din   (bus.inb),
    .q     (crc1_q)
  );

  always_comb begin
    bus.outb     = bus.inb;
    bus.sending  = 1'b0;
    bus.pause_in = 1'b0;
    case (state_reg)
      CALC: begin
        if (bus.recving) begin
          bus.sending = 1'b1;
        end else if (mode_reg == MODE_GEN) begin
          bus.sending  = 1'b1;
          bus.pause_in = 1'b1;
          bus.outb     = crc_bit;
        end
      end
      APPEND: begin
        bus.sending  = 1'b1;
        bus.pause_in = 1'b1;
        bus.outb     = crc_bit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= CRC_SEL0;
      mode_reg  <= MODE_GEN;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      ok_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.clear) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        ok_reg    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start) begin
              sel_reg   <= crc_sel_t'(bus.pkttype);
              mode_reg  <= crc_mode_t'(bus.chk_mode);
              ok_reg    <= 1'b0;
              state_reg <= CALC;
            end
          end
          CALC: begin
            if (!bus.recving) begin
              if (mode_reg == MODE_CHK) begin
                ok_reg    <= res_ok;
                done_reg  <= 1'b1;
                state_reg <= IDLE;
              end else if (!bus.pause_out) begin
                cnt_reg   <= CW'(1);
                state_reg <= APPEND;
              end
            end
          end
          APPEND: begin
            if (!bus.pause_out) begin
              if (cnt_reg == last_idx) begin
                cnt_reg   <= '0;
                state_reg <= IDLE;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.crc_done = done_reg;
  assign bus.crc_ok   = ok_reg;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: generate, pause, loopback check, clear, reset, stray start.
module tb_crc_serial_engine;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic pkt_bits [0:63];

  crc_serial_engine_if bus ();

  crc_serial_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: value appended on the wire (complemented register), right-aligned.
  function automatic logic [15:0] ref_crc(input bit sel, input int n);
    logic [15:0] c;
    logic [15:0] poly;
    logic [15:0] mask;
    logic        fb;
    int          w;
    w    = sel ? 16 : 5;
    poly = sel ? 16'h8005 : 16'h0005;
    mask = sel ? 16'hFFFF : 16'h001F;
    c    = mask;
    for (int i = 0; i < n; i++) begin
      fb = pkt_bits[i] ^ c[w-1];
      c  = ((c << 1) ^ (fb ? poly : 16'h0000)) & mask;
    end
    return ~c & mask;
  endfunction

  task automatic gen_pkt(input bit sel, input int n, input int pct, input int clear_at,
                         input int stray_at, output logic [15:0] crc, output int pin_cycles);
    int w;
    int got;
    int i;
    int cyc;
    w = sel ? 16 : 5;
    got = 0; i = 0; cyc = 0; crc = '0; pin_cycles = 0;
    tick();
    bus.start = 1'b1; bus.pkttype = sel; bus.chk_mode = 1'b0;
    bus.recving = 1'b0; bus.pause_out = 1'b0;
    tick();
    bus.start = 1'b0;
    while (i < n && cyc < 400) begin
      bus.recving   = 1'b1;
      bus.inb       = pkt_bits[i];
      bus.pause_out = ($urandom_range(99) < pct);
      @(negedge clk);
      check("pay_outb", bus.outb, bus.inb);
      check("pay_sending", bus.sending, 1);
      check("pay_pause_in", bus.pause_in, 0);
      if (!bus.pause_out) i++;
      tick();
      cyc++;
    end
    bus.recving = 1'b0;
    bus.inb     = 1'b0;
    while (got < w && cyc < 400) begin
      bus.pause_out = ($urandom_range(99) < pct);
      bus.clear     = (got == clear_at) && !bus.pause_out;
      bus.start     = (got == stray_at);
      if (bus.start) begin
        bus.pkttype  = ~sel;
        bus.chk_mode = 1'b1;
      end
      @(negedge clk);
      check("app_sending", bus.sending, 1);
      if (bus.pause_in) pin_cycles++;
      if (!bus.pause_out) begin
        crc = {crc[14:0], bus.outb};
        got++;
      end
      tick();
      cyc++;
      bus.start = 1'b0;
      if (bus.clear) begin
        bus.clear = 1'b0;
        break;
      end
    end
    bus.pause_out = 1'b0;
    @(negedge clk);
    check("end_sending", bus.sending, 0);
    check("end_pause_in", bus.pause_in, 0);
    check("cycle_budget", (cyc < 400), 1);
    if (clear_at < 0) check("app_count", got, w);
    $display("gen sel=%0d n=%0d crc=%h pause_in_cycles=%0d bits=%0d", sel, n, crc, pin_cycles, got);
  endtask

  task automatic chk_pkt(input bit sel, input int n, input bit exp_ok);
    tick();
    bus.start = 1'b1; bus.pkttype = sel; bus.chk_mode = 1'b1;
    bus.recving = 1'b0; bus.pause_out = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.recving = 1'b1;
      bus.inb     = pkt_bits[i];
      tick();
    end
    bus.recving = 1'b0;
    bus.inb     = 1'b0;
    @(negedge clk);
    check("chk_sending", bus.sending, 0);
    check("chk_done_early", bus.crc_done, 0);
    tick();
    @(negedge clk);
    check("chk_done_pulse", bus.crc_done, 1);
    check("chk_ok", bus.crc_ok, exp_ok);
    tick();
    @(negedge clk);
    check("chk_done_single", bus.crc_done, 0);
    check("chk_ok_held", bus.crc_ok, exp_ok);
    $display("chk sel=%0d n=%0d crc_ok=%0b expected=%0b", sel, n, bus.crc_ok, exp_ok);
  endtask

  initial begin
    logic [15:0] crc_a;
    logic [15:0] crc_b;
    logic [15:0] crc5;
    logic [15:0] crc_t;
    logic [10:0] token;
    int          pc;

    total = 0; bad = 0;
    rst = 1'b1;
    bus.clear = 1'b0; bus.start = 1'b0; bus.pkttype = 1'b0; bus.chk_mode = 1'b0;
    bus.inb = 1'b0; bus.recving = 1'b0; bus.pause_out = 1'b0;
    for (int i = 0; i < 64; i++) pkt_bits[i] = 1'b0;

    #12;
    check("rst_sending", bus.sending, 0);
    check("rst_pause_in", bus.pause_in, 0);
    check("rst_outb", bus.outb, 0);
    check("rst_crc_done", bus.crc_done, 0);
    check("rst_crc_ok", bus.crc_ok, 0);
    rst = 1'b0;

    // Zero-length CRC16: all-ones init complemented is sixteen zeros
    gen_pkt(1'b1, 0, 0, -1, -1, crc_t, pc);
    check("zl16_crc", crc_t, 16'h0000);
    check("zl16_pause_in", pc, 16);

    // Token addr 0x15 endp 0xE: USB CRC5 on the wire is 5'h17
    token = 11'h715;
    for (int i = 0; i < 11; i++) pkt_bits[i] = token[i];
    gen_pkt(1'b0, 11, 0, -1, -1, crc5, pc);
    check("tok_crc_hand", crc5, 16'h0017);
    check("tok_crc_ref", crc5, ref_crc(1'b0, 11));
    check("tok_pause_in", pc, 5);

    for (int k = 0; k < 5; k++) pkt_bits[11+k] = crc5[4-k];
    chk_pkt(1'b0, 16, 1'b1);
    pkt_bits[3] = ~pkt_bits[3];
    chk_pkt(1'b0, 16, 1'b0);
    pkt_bits[3] = ~pkt_bits[3];

    for (int i = 0; i < 32; i++) pkt_bits[i] = 1'($urandom_range(1));
    gen_pkt(1'b1, 32, 0, -1, -1, crc_a, pc);
    check("r16_crc_ref", crc_a, ref_crc(1'b1, 32));
    check("r16_pause_in", pc, 16);

    for (int k = 0; k < 16; k++) pkt_bits[32+k] = crc_a[15-k];
    chk_pkt(1'b1, 48, 1'b1);
    pkt_bits[40] = ~pkt_bits[40];
    chk_pkt(1'b1, 48, 1'b0);
    pkt_bits[40] = ~pkt_bits[40];
    chk_pkt(1'b1, 48, 1'b1);

    // clear in IDLE drops the held result
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    @(negedge clk);
    check("clr_idle_ok", bus.crc_ok, 0);
    check("clr_idle_done", bus.crc_done, 0);

    gen_pkt(1'b1, 32, 30, -1, -1, crc_b, pc);
    check("p30_crc", crc_b, crc_a);
    check("p30_pause_in_min", (pc >= 16), 1);

    gen_pkt(1'b1, 32, 0, 7, -1, crc_t, pc);
    check("clr_partial", crc_t[7:0], crc_a[15:8]);
    gen_pkt(1'b1, 32, 0, -1, -1, crc_t, pc);
    check("after_clr_crc", crc_t, crc_a);

    // Asynchronous reset in the middle of a payload
    tick();
    bus.start = 1'b1; bus.pkttype = 1'b1; bus.chk_mode = 1'b0;
    tick();
    bus.start = 1'b0; bus.recving = 1'b1; bus.inb = 1'b1;
    tick();
    tick();
    check("pre_rst_sending", bus.sending, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sending", bus.sending, 0);
    check("arst_pause_in", bus.pause_in, 0);
    check("arst_crc_done", bus.crc_done, 0);
    check("arst_crc_ok", bus.crc_ok, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_idle", bus.sending, 0);
    bus.recving = 1'b0; bus.inb = 1'b0;
    $display("rst mid-packet sending=%0b", bus.sending);

    for (int i = 0; i < 11; i++) pkt_bits[i] = token[i];
    gen_pkt(1'b0, 11, 0, -1, -1, crc_t, pc);
    check("post_rst_tok", crc_t, 16'h0017);

    // Stray start during APPEND must not relatch the flavour
    gen_pkt(1'b1, 0, 0, -1, 4, crc_t, pc);
    check("stray_crc", crc_t, 16'h0000);
    check("stray_pause_in", pc, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
